rd_data_conv: RTL

Converts the 32-bit SSD read-data stream from the SATA HBA back into the memcached memory read path. It is the read-direction counterpart of the write-path converter: the HBA always returns whole 512-byte sectors (128 × 32-bit words), and this block forwards only the requested words to memcached, discarding the sector padding. Per-command word counts arrive from McdCmdAdapter. The block runs on the 150 MHz SSD-controller clock.

---
 rtl/rd_data_conv.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rd_data_conv.sv
// rd_data_conv: SSD sector read stream -> memcached read data path.
// Optional nonzero-padding checker: define RDCONV_PAD_CHECK_EN.

module reg_fifo #(
  parameter int W          = 32,
  parameter int DEPTH_BITS = 4
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full_n,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty_n
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  // A write on a full FIFO is refused even if a pop happens that cycle
  assign full_n  = (count != FULL_CNT);
  assign empty_n = (count != '0);
  assign do_wr   = wr_en & full_n;
  assign do_rd   = rd_en & empty_n;
  assign rd_data = mem[rd_ptr];

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module axi_reg_slice #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [N-1:0] m_data,
  input  logic         m_ready
);
  assign s_ready = ~m_valid | m_ready;

  // Single output register; contents hold while the sink stalls
  always_ff @(posedge clk) begin
    if (!nReset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) m_data <= s_data;
    end
  end
endmodule

module rd_data_conv #(
  parameter int SECTOR_LOG2      = 7,
  parameter int DFIFO_DEPTH_BITS = 4,
  parameter int CFIFO_DEPTH_BITS = 4
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [31:0] rdata,
  input  logic        rdata_en,
  output logic        rdata_full,
  input  logic [15:0] num_words,
  input  logic        rd_num_words_en,
  output logic        rd_num_words_ready,
  output logic [31:0] dramRdData_data,
  output logic        dramRdData_valid,
  input  logic        dramRdData_ready,
  output logic        pad_err,
  output logic [1:0]  curr_state_r_de,
  output logic [15:0] curr_words_r_de
);
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SET_COUNTER = 2'd1,
    FORWARD     = 2'd2,
    DISCARD     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] num_words_r;
  logic [16:0] curr_words;
  logic [16:0] cw_inc;
  logic        last_fwd;
  logic        sect_end;

  logic        c_full_n;
  logic        c_empty_n;
  logic [15:0] c_rdata;
  logic        c_pop;

  logic        d_full_n;
  logic        d_empty_n;
  logic [31:0] d_rdata;
  logic        d_pop;

  logic        s_valid;
  logic        s_ready;

  reg_fifo #(
    .W          (16),
    .DEPTH_BITS (CFIFO_DEPTH_BITS)
  ) u_cfifo (
    .clk     (clk),
    .nReset  (nReset),
    .wr_en   (rd_num_words_en),
    .wr_data (num_words),
    .full_n  (c_full_n),
    .rd_en   (c_pop),
    .rd_data (c_rdata),
    .empty_n (c_empty_n)
  );

  reg_fifo #(
    .W          (32),
    .DEPTH_BITS (DFIFO_DEPTH_BITS)
  ) u_dfifo (
    .clk     (clk),
    .nReset  (nReset),
    .wr_en   (rdata_en),
    .wr_data (rdata),
    .full_n  (d_full_n),
    .rd_en   (d_pop),
    .rd_data (d_rdata),
    .empty_n (d_empty_n)
  );

  axi_reg_slice #(
    .N (32)
  ) u_slice (
    .clk     (clk),
    .nReset  (nReset),
    .s_valid (s_valid),
    .s_data  (d_rdata),
    .s_ready (s_ready),
    .m_valid (dramRdData_valid),
    .m_data  (dramRdData_data),
    .m_ready (dramRdData_ready)
  );

  assign rd_num_words_ready = c_full_n;
  assign rdata_full         = ~d_full_n;

  // 17-bit count so the compare still works at num_words = 65535
  assign cw_inc   = curr_words + 17'd1;
  assign last_fwd = (cw_inc == {1'b0, num_words_r});
  assign sect_end = (cw_inc[SECTOR_LOG2-1:0] == '0);

  // Next state and pop strobes; data only moves in FORWARD/DISCARD
  always_comb begin
    state_nxt = state;
    c_pop     = 1'b0;
    d_pop     = 1'b0;
    s_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (c_empty_n) state_nxt = SET_COUNTER;
      end
      SET_COUNTER: begin
        c_pop = 1'b1;
        if (c_rdata == '0) state_nxt = IDLE;
        else               state_nxt = FORWARD;
      end
      FORWARD: begin
        if (d_empty_n && s_ready) begin
          d_pop   = 1'b1;
          s_valid = 1'b1;
          if (last_fwd) begin
            if (num_words_r[SECTOR_LOG2-1:0] == '0)
              state_nxt = IDLE;
            else
              state_nxt = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (d_empty_n) begin
          d_pop = 1'b1;
          if (sect_end) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, command length and word counter
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state       <= IDLE;
      num_words_r <= '0;
      curr_words  <= '0;
    end else begin
      state <= state_nxt;
      if (state == SET_COUNTER) begin
        num_words_r <= c_rdata;
        curr_words  <= '0;
      end else if (d_pop) begin
        curr_words <= cw_inc;
      end
    end
  end

`ifdef RDCONV_PAD_CHECK_EN
  logic pad_err_r;

  // Flag any nonzero word dropped as padding; held until reset
  always_ff @(posedge clk) begin
    if (!nReset)
      pad_err_r <= 1'b0;
    else if (state == DISCARD && d_pop && d_rdata != '0)
      pad_err_r <= 1'b1;
  end

  assign pad_err = pad_err_r;
`else
  assign pad_err = 1'b0;
`endif

  assign curr_state_r_de = state;
  assign curr_words_r_de = curr_words[15:0];
endmodule
